wb_axis_in_bridge: RTL and testbench

//  Parametrised Wishbone-slave to AXI-Stream master bridge. The Caravel firmware writes data words over Wishbone.
//  A circular FIFO buffers them, and they drive ss_* into the FIR input stream. Adds flush, a status/count register,

---
 rtl/wb_axisin_pkg.sv | 26 ++
 rtl/wb_axisin_fifo.sv | 68 ++++++
 rtl/wb_axis_in_bridge.sv | 190 +++++++++++++++++++
 tb/tb_wb_axis_in_bridge.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_axisin_pkg.sv
// Shared definitions for the Wishbone-to-AXI-Stream input bridge.
//  - Register offsets decoded from wbs_adr_i[7:0]
//  - STATUS / CTRL bit positions
//  - Bus-side FSM state type
package wb_axisin_pkg;

    localparam logic [7:0] REG_DATALEN = 8'h10;
    localparam logic [7:0] REG_PUSH    = 8'h80;
    localparam logic [7:0] REG_STATUS  = 8'h84;
    localparam logic [7:0] REG_FULL    = 8'h88;
    localparam logic [7:0] REG_CTRL    = 8'h8C;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    localparam int unsigned CTRL_FLUSH_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_axisin_fifo.sv
// Circular FIFO feeding the stream side of the bridge.
// Ports:
//  clk_i, rst_i      clock, asynchronous active-high reset (pointers only)
//  push_i, data_i    write request and word; ignored while full
//  pop_i             read request; ignored while empty
//  flush_i           empties the FIFO; wins over a same-cycle pop
//  head_o            oldest entry
//  count_o           occupancy 0..Depth
//  full_o, empty_o   occupancy flags
module wb_axisin_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [Width-1:0]         head_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [CntW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit lets full and empty be told apart by subtraction.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CntW'(Depth));
    assign empty_o = (count_o == '0);
    assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + CntW'(do_push);
        rd_ptr_d = rd_ptr_q + CntW'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/wb_axis_in_bridge.sv
// Wishbone slave that buffers firmware-written words and streams them out as an AXI-Stream master.
// Registers (offset on wbs_adr_i[7:0], block selected by wbs_adr_i[31:24] == pADDR_BASE):
//  0x10 DATA_LEN (RW), 0x80 push (W), 0x84 STATUS (R), 0x88 FULL (R), 0x8C CTRL (flush, irq_en)
// Ports:
//  wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//  wbs_*                      Wishbone slave; ack is a registered one-cycle pulse
//  ss_tvalid/tdata/tlast      stream output, ss_tready from the consumer
//  irq_o                      low-watermark level, only when WB_AXISIN_IRQ_EN is defined
// Build option: WB_AXISIN_IRQ_EN adds irq_o, the threshold logic and CTRL bit1.
module wb_axis_in_bridge
    import wb_axisin_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pDEPTH      = 16,
    parameter logic [7:0]  pADDR_BASE  = 8'h30,
    parameter int unsigned pLOW_WM     = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
`ifdef WB_AXISIN_IRQ_EN
    ,
    output logic                   irq_o
`endif
);
    localparam int unsigned CntW = $clog2(pDEPTH) + 1;

    wb_state_e       state_q, state_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     data_len_q, data_len_d;
    logic [31:0]     beat_cnt_q, beat_cnt_d;

    logic            req, is_push, data_len_wr;
    logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [7:0]      offset;
    logic [31:0]     rd_data;
    logic            unused_inputs;

`ifdef WB_AXISIN_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
`endif

    assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[23:8]};

    assign offset  = wbs_adr_i[7:0];
    assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == pADDR_BASE);
    assign is_push = wbs_we_i & (offset == REG_PUSH);

    wb_axisin_fifo #(
        .Width (pDATA_WIDTH),
        .Depth (pDEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (fifo_push),
        .data_i  (wbs_dat_i[pDATA_WIDTH-1:0]),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (ss_tdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ss_tvalid = ~fifo_empty;
    assign fifo_pop  = ss_tvalid & ss_tready;
    assign ss_tlast  = ss_tvalid & (data_len_q != '0) & (beat_cnt_q == data_len_q - 32'd1);
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        rd_data = '0;
        case (offset)
            REG_DATALEN: rd_data = data_len_q;
            REG_STATUS: begin
                rd_data[STATUS_COUNT_LSB +: CntW] = fifo_count;
                rd_data[STATUS_EMPTY_BIT]         = fifo_empty;
                rd_data[STATUS_FULL_BIT]          = fifo_full;
            end
            REG_FULL: rd_data[0] = fifo_full;
`ifdef WB_AXISIN_IRQ_EN
            REG_CTRL: rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dat_d       = '0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        data_len_wr = 1'b0;
`ifdef WB_AXISIN_IRQ_EN
        irq_en_d    = irq_en_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (is_push) begin
                        if (!fifo_full) begin
                            fifo_push = 1'b1;
                            state_d   = StAck;
                        end else begin
                            state_d   = StWait;
                        end
                    end else begin
                        state_d = StAck;
                        if (wbs_we_i) begin
                            data_len_wr = (offset == REG_DATALEN);
                            if (offset == REG_CTRL) begin
                                fifo_flush = wbs_dat_i[CTRL_FLUSH_BIT];
`ifdef WB_AXISIN_IRQ_EN
                                irq_en_d   = wbs_dat_i[CTRL_IRQ_EN_BIT];
`endif
                            end
                        end else begin
                            dat_d = rd_data;
                        end
                    end
                end
            end
            // Master holds the write data while stalled; retry once a slot frees.
            StWait: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ack_d = (state_d == StAck);
    end

    always_comb begin
        data_len_d = data_len_wr ? wbs_dat_i : data_len_q;
        beat_cnt_d = beat_cnt_q;
        if (fifo_flush || data_len_wr) begin
            beat_cnt_d = '0;
        end else if (fifo_pop) begin
            beat_cnt_d = ss_tlast ? '0 : beat_cnt_q + 32'd1;
        end
    end

`ifdef WB_AXISIN_IRQ_EN
    assign irq_d = irq_en_q & (32'(fifo_count) <= pLOW_WM);
    assign irq_o = irq_q;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            data_len_q <= '0;
            beat_cnt_q <= '0;
`ifdef WB_AXISIN_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            data_len_q <= data_len_d;
            beat_cnt_q <= beat_cnt_d;
`ifdef WB_AXISIN_IRQ_EN
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_axis_in_bridge.sv
// Self-checking bench for wb_axis_in_bridge: directed sequences with random data, a word queue
// as the stream model and frame position kept as a plain beat tally modulo DATA_LEN.
module tb_wb_axis_in_bridge;
    localparam int unsigned Depth = 16;
    localparam logic [7:0]  Base  = 8'h30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic        ss_tvalid, ss_tlast;
    logic        ss_tready = 1'b0;
    logic [31:0] ss_tdata;
`ifdef WB_AXISIN_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    wb_axis_in_bridge #(
        .pDATA_WIDTH (32),
        .pDEPTH      (Depth),
        .pADDR_BASE  (Base),
        .pLOW_WM     (4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready)
`ifdef WB_AXISIN_IRQ_EN
        ,
        .irq_o     (irq)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] data_len = '0;
    longint      beats_since = 0;
    int          n_beats = 0, n_last = 0;
    logic [31:0] last_word = '0;
    logic [31:0] mon_word;
    logic        mon_last;
    bit          tog_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Stream monitor: every accepted beat must be the oldest queued word, tlast every DATA_LEN-th.
    always @(negedge clk) begin
        if (!rst && ss_tvalid && ss_tready) begin
            if (exp_q.size() == 0) begin
                check("beat_without_word", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_word = exp_q.pop_front();
                mon_last = (data_len != 0) && (((beats_since + 1) % longint'(data_len)) == 0);
                check("tdata", ss_tdata, mon_word);
                check("tlast", 32'(ss_tlast), 32'(mon_last));
                beats_since++;
                n_beats++;
                if (ss_tlast) n_last++;
                last_word = ss_tdata;
            end
        end
    end

    function automatic logic [31:0] status_exp(input int n);
        return (32'(n) << 8) | ((n == 0) ? 32'd2 : 32'd0) | ((n == Depth) ? 32'd1 : 32'd0);
    endfunction

    task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = {Base, 16'h0, off}; wdat = d;
        lat = 0;
        rd  = '0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 50);
        if (ack) begin
            rd = rdat_o;
            if (w && off == 8'h80) exp_q.push_back(d);
        end else begin
            check("xfer_timeout", 32'(ack), 32'd1);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b0, off, 32'h0, r, lat);
        check(tag, r, exp);
        check("rd_latency", 32'(lat), 32'd1);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, off, d, r, lat);
        check("wr_latency", 32'(lat), 32'd1);
        if (off == 8'h10) begin
            data_len    = d;
            beats_since = 0;
        end
        if (off == 8'h8C && d[0]) begin
            exp_q.delete();
            beats_since = 0;
        end
    endtask

    task automatic push(input logic [31:0] d);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, 8'h80, d, r, lat);
        check("push_latency", 32'(lat), 32'd1);
    endtask

    task automatic chk_status(input string tag);
        rd_chk(tag, 8'h84, status_exp(exp_q.size()));
    endtask

    task automatic drain(input string tag);
        ss_tready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_tvalid_low"}, 32'(ss_tvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] w17;
        int lat;
        int b0, l0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat_o, 32'd0);
        check("rst_tvalid", 32'(ss_tvalid), 32'd0);
        check("rst_tlast", 32'(ss_tlast), 32'd0);
`ifdef WB_AXISIN_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_datalen", 8'h10, 32'd0);
        rd_chk("rst_status", 8'h84, 32'h2);

        // 1: one five-beat frame
        wr(8'h10, 32'd5);
        rd_chk("datalen_rb", 8'h10, 32'd5);
        ss_tready = 1'b1;
        for (int i = 1; i <= 5; i++) push(32'(i));
        drain("t1");
        check("t1_beats", 32'(n_beats), 32'd5);
        check("t1_tlast_count", 32'(n_last), 32'd1);

        // 2: back-pressure, the 17th push stalls until a slot frees
        ss_tready = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            push($urandom);
            if (i == Depth - 2) rd_chk("t2_full_15", 8'h88, 32'd0);
        end
        rd_chk("t2_full_16", 8'h88, 32'd1);
        chk_status("t2_status_full");
        w17 = $urandom;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {Base, 16'h0, 8'h80}; wdat = w17;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t2_stall_noack", 32'(ack), 32'd0);
        end
        ss_tready = 1'b1;
        lat = 0;
        while (!ack && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t2_ack_within_2", 32'(lat <= 2 && ack), 32'd1);
        if (ack) exp_q.push_back(w17);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        drain("t2");
        check("t2_last_word", last_word, w17);

        // 3: random words while tready toggles
        ss_tready = 1'b1;
        tog_en = 1'b1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk); #1;
                    ss_tready = ~ss_tready;
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    push($urandom);
                    chk_status("t3_status");
                end
                tog_en = 1'b0;
            end
        join
        drain("t3");

        // 4: flush mid-frame, next frame restarts at beat 1
        wr(8'h10, 32'd4);
        ss_tready = 1'b1;
        push($urandom);
        push($urandom);
        drain("t4_pre");
        ss_tready = 1'b0;
        for (int i = 0; i < 7; i++) push($urandom);
        chk_status("t4_status_7");
        wr(8'h8C, 32'd1);
        check("t4_tvalid_after_flush", 32'(ss_tvalid), 32'd0);
        rd_chk("t4_status_flushed", 8'h84, 32'h2);
        rd_chk("t4_ctrl_selfclear", 8'h8C, 32'd0);
        b0 = n_beats;
        l0 = n_last;
        ss_tready = 1'b1;
        for (int i = 0; i < 4; i++) push($urandom);
        drain("t4");
        check("t4_beats", 32'(n_beats - b0), 32'd4);
        check("t4_one_tlast", 32'(n_last - l0), 32'd1);

        // 5: unmapped / wrong-direction accesses
        ss_tready = 1'b0;
        for (int i = 0; i < 3; i++) push($urandom);
        rd_chk("t5_read_unmapped", 8'h40, 32'd0);
        check("t5_dat_idle_zero", rdat_o, 32'd0);
        wr(8'h44, 32'hFFFF_FFFF);
        rd_chk("t5_read_push_reg", 8'h80, 32'd0);
        wr(8'h84, 32'hFFFF_FFFF);
        wr(8'h88, 32'hFFFF_FFFF);
        chk_status("t5_status_kept");
        rd_chk("t5_datalen_kept", 8'h10, 32'd4);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {8'h31, 16'h0, 8'h80}; wdat = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_other_base_noack", 32'(ack), 32'd0);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk_status("t5_status_after_miss");
        drain("t5");

`ifdef WB_AXISIN_IRQ_EN
        // 6: low-watermark interrupt follows count with one cycle of delay
        begin
            int prev;
            check("t6_irq_disabled", 32'(irq), 32'd0);
            ss_tready = 1'b0;
            wr(8'h8C, 32'd2);
            rd_chk("t6_ctrl_rb", 8'h8C, 32'd2);
            for (int i = 0; i < 6; i++) push($urandom);
            check("t6_irq_above_wm", 32'(irq), 32'd0);
            prev = exp_q.size();
            ss_tready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                check("t6_irq_track", 32'(irq), 32'(prev <= 4));
                prev = exp_q.size();
            end
            wr(8'h8C, 32'd0);
            check("t6_irq_cleared", 32'(irq), 32'd0);
        end
`endif

        // Reset while stalled in WAIT: no ack, FIFO discarded
        ss_tready = 1'b0;
        for (int i = 0; i < Depth; i++) push($urandom);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {Base, 16'h0, 8'h80}; wdat = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_tvalid", 32'(ss_tvalid), 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ack_held", 32'(ack), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        data_len    = '0;
        beats_since = 0;
        @(posedge clk); #1;
        rd_chk("rst_mid_status", 8'h84, 32'h2);
        rd_chk("rst_mid_datalen", 8'h10, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
